softmax_norm_64: RTL and testbench
==================================

Name: softmax_norm_64

Overview:
- Normalisation stage directly downstream of the 64-lane fixed-point adder tree in the tree-based softmax approximation.
- Accepts one vector of 64 exponent values plus the group sums the tree produced (one 64-group, two 32-groups, or four 16-groups, selected by length_mode).
- For each group, computes a reciprocal of the group sum with a shared multi-cycle restoring divider.
- Scales every element by its group's reciprocal and presents the normalised 64-lane vector on a valid/ready output handshake.

Parameters:
- Q_FRAC, 31, reciprocal numerator exponent: R = floor(2^Q_FRAC / S). Output fraction bits = Q_FRAC-16 (default UQ1.15).
- DIV_ITERS, 32, restoring-divider iterations per group. Must equal the quotient width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  global clock enable; when low, all registers hold
- length_mode  in  2  0: one group of 64; 1: two groups of 32; 2: four groups of 16; 3: treated as 0
- valid_in  in  1  input vector and sums valid
- ready_in  out  1  block can accept an input (state IDLE)
- data_flat  in  1024  64 unsigned 16-bit exponent values; lane i = [i*16 +: 16]
- sum_64_0  in  16  group sum used in mode 0
- sum_32_0, sum_32_1  in  16 each  group sums used in mode 1
- sum_16_0 .. sum_16_3  in  16 each  group sums used in mode 2
- valid_out  out  1  normalised vector valid
- ready_out  in  1  consumer accepts output
- out_flat  out  1024  64 normalised unsigned 16-bit values
- length_mode_out  out  2  length_mode of the vector currently on the output (3 is reported as 0)
- div_zero  out  4  bit g set if group g had a sum of 0

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; valid_out = 0; out_flat = 0; length_mode_out = 0; div_zero = 0; internal data, sums, reciprocals and counters = 0.
- ready_in = (state == IDLE), combinational. Acceptance happens on a clock edge where en & valid_in & ready_in are all 1.
- On acceptance:
  - Latch data_flat and the effective mode.
  - Latch the G selected sums, with G = 1, 2 or 4.
  - Go to DIV with group index g = 0 and iteration count 0.
- DIV state:
  - One restoring-division iteration per enabled edge, computing the 32-bit quotient floor(2^Q_FRAC / S_g).
  - After DIV_ITERS iterations, store R_g and advance g.
  - After group G-1 completes, go to MUL.
  - If S_g == 0: R_g = 0, div_zero[g] is set, and the group still consumes DIV_ITERS cycles so latency stays fixed.
- MUL state (one enabled edge):
  - For each lane i in group g, form the 48-bit product P = x_i * R_g and take y_i = P[31:16].
  - If P[47:32] != 0, y_i saturates to 0xFFFF.
  - Register out_flat, length_mode_out and div_zero; set valid_out = 1; go to OUT.
- Latency: valid_out rises after edge number DIV_ITERS*G + 1 counted from the acceptance edge, i.e. 33 / 65 / 129 enabled edges for modes 0 / 1 / 2.
- OUT state:
  - Outputs are held stable while ready_out = 0.
  - On an enabled edge with ready_out = 1: valid_out = 0 and state = IDLE.
  - There is no overlap; a new input can be accepted only from the following cycle.
- valid_in while not in IDLE is ignored. It is never buffered.
- en low: no state, counter, datapath or output register changes. Latency extends by the number of en-low cycles.
- Group-to-lane mapping:
  - Mode 1: lanes 0-31 use group 0, lanes 32-63 use group 1.
  - Mode 2: lanes 16g .. 16g+15 use group g.
  - Unused div_zero bits are 0.
- When each group's sum equals the sum of its lanes, no saturation occurs and y_i <= 2^(Q_FRAC-16).

Test Plan:
1. Mode 0, all lanes 0x0100, sum_64_0 = 0x4000 -> R = 131072; every lane = 0x0200; valid_out rises 33 edges after acceptance; div_zero = 0.
2. Mode 2, lanes 0-15 = 0x0001 with sum_16_0 = 16; lane 16 = 0x1000 and lanes 17-31 = 0 with sum_16_1 = 0x1000; groups 2-3 lanes = 0x0004 with sums 64 -> lanes 0-15 = 0x0800; lane 16 = 0x8000; lanes 17-31 = 0; lanes 32-63 = 0x0800; latency 129.
3. Mode 1 with sum_32_1 = 0 and lanes 32-63 nonzero -> lanes 32-63 = 0, div_zero = 4'b0001 << 1. Also mode 0 with lane 0 = 0x0200 and sum = 0x0100 -> lane 0 = 0xFFFF (saturation).
4. Backpressure: hold ready_out = 0 for 10 cycles after valid_out rises while driving valid_in = 1 -> out_flat stable, ready_in = 0, no acceptance. Raise ready_out -> valid_out = 0 and ready_in = 1 on the next edge.
5. Reset mid-DIV: pulse rst_n low during cycle 20 of mode 0 -> valid_out, out_flat and div_zero are immediately 0 and ready_in = 1. A following input produces a correct result with full latency.
6. en low for 5 cycles during DIV (mode 0, data from test 1) -> valid_out after 38 edges; results identical to test 1.

Source files
------------

// File: rtl/softmax_norm_64.sv
`default_nettype none
// ============================================================================
// Module   : softmax_norm_64
// Brief    : Per-group reciprocal (shared restoring divider) and 64-lane scale
//            stage for the tree-based softmax approximation.
// Revision : 1.0 - initial release
// ============================================================================
module softmax_norm_64 #(
  parameter int Q_FRAC    = 31,
  parameter int DIV_ITERS = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    length_mode,
  input  logic          valid_in,
  output logic          ready_in,
  input  logic [1023:0] data_flat,
  input  logic [15:0]   sum_64_0,
  input  logic [15:0]   sum_32_0,
  input  logic [15:0]   sum_32_1,
  input  logic [15:0]   sum_16_0,
  input  logic [15:0]   sum_16_1,
  input  logic [15:0]   sum_16_2,
  input  logic [15:0]   sum_16_3,
  output logic          valid_out,
  input  logic          ready_out,
  output logic [1023:0] out_flat,
  output logic [1:0]    length_mode_out,
  output logic [3:0]    div_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam int                  c_ITER_W    = $clog2(DIV_ITERS);
  localparam logic [c_ITER_W-1:0] c_LAST_ITER = c_ITER_W'(DIV_ITERS - 1);
  // Iteration at which the single set bit of the 2^Q_FRAC numerator enters.
  localparam logic [c_ITER_W-1:0] c_ONE_ITER  = c_ITER_W'(DIV_ITERS - 1 - Q_FRAC);

  logic [1:0]                     r_state;
  logic [1:0]                     w_next;
  logic [1023:0]                  r_data;
  logic [1:0]                     r_mode;
  logic [3:0][15:0]               r_sums;
  logic [3:0][DIV_ITERS-1:0]      r_recip;
  logic [3:0]                     r_zero;
  logic [1:0]                     r_grp;
  logic [c_ITER_W-1:0]            r_iter;
  logic [15:0]                    r_rem;
  logic [DIV_ITERS-1:0]           r_quo;

  logic [1:0]                     w_mode_eff;
  logic [1:0]                     w_glast;
  logic                           w_last_iter;
  logic [15:0]                    w_div;
  logic [16:0]                    w_rem_sh;
  logic                           w_ge;
  logic [15:0]                    w_rem_nx;
  logic [DIV_ITERS-1:0]           w_quo_nx;
  logic [63:0][15:0]              w_y;

  assign w_mode_eff  = (length_mode == 2'd3) ? 2'd0 : length_mode;
  assign w_glast     = (r_mode == 2'd1) ? 2'd1 : ((r_mode == 2'd2) ? 2'd3 : 2'd0);
  assign w_last_iter = (r_iter == c_LAST_ITER);

  // One restoring step: shift in the next numerator bit, subtract if it fits.
  assign w_div    = r_sums[r_grp];
  assign w_rem_sh = {r_rem, (r_iter == c_ONE_ITER)};
  assign w_ge     = (w_rem_sh >= {1'b0, w_div});
  assign w_rem_nx = w_ge ? 16'(w_rem_sh - {1'b0, w_div}) : w_rem_sh[15:0];
  assign w_quo_nx = {r_quo[DIV_ITERS-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (en) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (valid_in) w_next = S_DIV;
      S_DIV:   if (w_last_iter && (r_grp == w_glast)) w_next = S_MUL;
      S_MUL:   w_next = S_OUT;
      S_OUT:   if (ready_out) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_in = (r_state == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data          <= '0;
      r_mode          <= 2'd0;
      r_sums          <= '0;
      r_recip         <= '0;
      r_zero          <= 4'd0;
      r_grp           <= 2'd0;
      r_iter          <= '0;
      r_rem           <= 16'd0;
      r_quo           <= '0;
      valid_out       <= 1'b0;
      out_flat        <= '0;
      length_mode_out <= 2'd0;
      div_zero        <= 4'd0;
    end else if (en) begin
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            r_data  <= data_flat;
            r_mode  <= w_mode_eff;
            r_recip <= '0;
            r_zero  <= 4'd0;
            r_grp   <= 2'd0;
            r_iter  <= '0;
            r_rem   <= 16'd0;
            r_quo   <= '0;
            case (w_mode_eff)
              2'd1:    r_sums <= {16'd0, 16'd0, sum_32_1, sum_32_0};
              2'd2:    r_sums <= {sum_16_3, sum_16_2, sum_16_1, sum_16_0};
              default: r_sums <= {16'd0, 16'd0, 16'd0, sum_64_0};
            endcase
          end
        end
        S_DIV: begin
          if (w_last_iter) begin
            // A zero sum still runs the full iteration count to keep latency fixed.
            r_recip[r_grp] <= (w_div == 16'd0) ? '0 : w_quo_nx;
            r_zero[r_grp]  <= (w_div == 16'd0);
            r_grp          <= r_grp + 2'd1;
            r_iter         <= '0;
            r_rem          <= 16'd0;
            r_quo          <= '0;
          end else begin
            r_iter <= r_iter + 1'b1;
            r_rem  <= w_rem_nx;
            r_quo  <= w_quo_nx;
          end
        end
        S_MUL: begin
          out_flat        <= w_y;
          length_mode_out <= r_mode;
          div_zero        <= r_zero;
          valid_out       <= 1'b1;
        end
        S_OUT: begin
          if (ready_out) valid_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < 64; i++) begin : g_lane
    localparam int c_G32 = i / 32;
    localparam int c_G16 = i / 16;
    logic [1:0]  w_sel;
    logic [47:0] w_prod;

    always_comb begin
      w_sel = 2'd0;
      if (r_mode == 2'd1)      w_sel = 2'(c_G32);
      else if (r_mode == 2'd2) w_sel = 2'(c_G16);
    end

    assign w_prod = {32'd0, r_data[i*16 +: 16]} * {{(48-DIV_ITERS){1'b0}}, r_recip[w_sel]};
    assign w_y[i] = (|w_prod[47:32]) ? 16'hFFFF : w_prod[31:16];
  end

endmodule
`default_nettype wire

// File: tb/tb_softmax_norm_64.sv
`default_nettype none
// ============================================================================
// Module   : tb_softmax_norm_64
// Brief    : Directed + randomised scoreboard bench for softmax_norm_64.
// Revision : 1.0 - initial release
// ============================================================================
module tb_softmax_norm_64;

  logic          clk = 1'b0;
  logic          rst_n, en, valid_in, ready_in, valid_out, ready_out;
  logic [1:0]    length_mode, length_mode_out;
  logic [1023:0] data_flat, out_flat;
  logic [15:0]   sum_64_0, sum_32_0, sum_32_1, sum_16_0, sum_16_1, sum_16_2, sum_16_3;
  logic [3:0]    div_zero;

  typedef struct {
    logic [1023:0] y;
    logic [1:0]    m;
    logic [3:0]    dz;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  logic [1023:0] last_y;
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

  softmax_norm_64 dut (
    .clk(clk), .rst_n(rst_n), .en(en), .length_mode(length_mode),
    .valid_in(valid_in), .ready_in(ready_in), .data_flat(data_flat),
    .sum_64_0(sum_64_0), .sum_32_0(sum_32_0), .sum_32_1(sum_32_1),
    .sum_16_0(sum_16_0), .sum_16_1(sum_16_1), .sum_16_2(sum_16_2), .sum_16_3(sum_16_3),
    .valid_out(valid_out), .ready_out(ready_out), .out_flat(out_flat),
    .length_mode_out(length_mode_out), .div_zero(div_zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    int lane;
    lane = 0;
    for (int i = 63; i >= 0; i--) if (got[i*16 +: 16] !== exp[i*16 +: 16]) lane = i;
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s lane=%0d got=%h exp=%h", tag, lane, got[lane*16 +: 16], exp[lane*16 +: 16]);
    end
  endtask

  // Reference: R = floor(2^31/S) (0 if S==0), y = sat16((x*R) >> 16).
  function automatic exp_t model(input logic [1:0] m);
    exp_t             e;
    logic [1:0]       me;
    logic [3:0][15:0] gs;
    int               ng, g;
    logic [63:0]      r, p;
    me = (m == 2'd3) ? 2'd0 : m;
    gs = '0;
    case (me)
      2'd1:    begin gs[0] = sum_32_0; gs[1] = sum_32_1; ng = 2; end
      2'd2:    begin gs = {sum_16_3, sum_16_2, sum_16_1, sum_16_0}; ng = 4; end
      default: begin gs[0] = sum_64_0; ng = 1; end
    endcase
    e.m  = me;
    e.dz = 4'd0;
    e.y  = '0;
    for (int k = 0; k < ng; k++) e.dz[k] = (gs[k] == 16'd0);
    for (int i = 0; i < 64; i++) begin
      g = (me == 2'd1) ? i / 32 : ((me == 2'd2) ? i / 16 : 0);
      r = (gs[g] == 16'd0) ? 64'd0 : 64'h8000_0000 / {48'd0, gs[g]};
      p = {48'd0, data_flat[i*16 +: 16]} * r;
      e.y[i*16 +: 16] = (p[47:32] != 16'd0) ? 16'hFFFF : p[31:16];
    end
    e.lat = 32 * ng + 1;
    return e;
  endfunction

  task automatic do_accept();
    int w;
    w = 0;
    while (ready_in !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk("ready_in_idle", ready_in, 1);
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk("ready_in_busy", ready_in, 0);
  endtask

  // Accept the current inputs, wait for valid_out, compare against the scoreboard.
  task automatic run_check(input string tag, input int el_at, input int el_len);
    exp_t e;
    int   cnt;
    e = model(length_mode);
    e.lat += el_len;
    sb.push_back(e);
    do_accept();
    cnt = 0;
    while (valid_out !== 1'b1 && cnt < 400) begin
      @(posedge clk); #1; cnt++;
      if (el_len > 0 && cnt == el_at)          en = 1'b0;
      if (el_len > 0 && cnt == el_at + el_len) en = 1'b1;
    end
    en = 1'b1;
    e = sb.pop_front();
    chk({tag, "_latency"}, cnt, e.lat);
    chk_vec({tag, "_out"}, out_flat, e.y);
    chk({tag, "_mode_out"}, length_mode_out, e.m);
    chk({tag, "_div_zero"}, div_zero, e.dz);
    last_y = e.y;
  endtask

  task automatic release_out(input string tag);
    ready_out = 1'b1;
    @(posedge clk); #1;
    ready_out = 1'b0;
    valid_in  = 1'b0;
    chk({tag, "_valid_drop"}, valid_out, 0);
    chk({tag, "_ready_back"}, ready_in, 1);
  endtask

  task automatic zero_sums();
    sum_64_0 = 0; sum_32_0 = 0; sum_32_1 = 0;
    sum_16_0 = 0; sum_16_1 = 0; sum_16_2 = 0; sum_16_3 = 0;
  endtask

  task automatic load_t1();
    zero_sums();
    length_mode = 2'd0;
    for (int i = 0; i < 64; i++) data_flat[i*16 +: 16] = 16'h0100;
    sum_64_0 = 16'h4000;
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] acc[4];
    rst_n = 1'b0; en = 1'b1; valid_in = 1'b0; ready_out = 1'b0;
    data_flat = '0; length_mode = 2'd0; last_y = '0;
    zero_sums();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_ready_in", ready_in, 1);
    chk_vec("rst_out_flat", out_flat, '0);
    chk("rst_mode_out", length_mode_out, 0);
    chk("rst_div_zero", div_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Mode 0, uniform lanes
    load_t1();
    run_check("t1", 0, 0);
    release_out("t1");

    // Mode 2, four groups with different reciprocals
    zero_sums();
    length_mode = 2'd2;
    for (int i = 0; i < 64; i++) begin
      if (i < 16)       v = 16'h0001;
      else if (i == 16) v = 16'h1000;
      else if (i < 32)  v = 16'h0000;
      else              v = 16'h0004;
      data_flat[i*16 +: 16] = v;
    end
    sum_16_0 = 16; sum_16_1 = 16'h1000; sum_16_2 = 64; sum_16_3 = 64;
    run_check("t2", 0, 0);
    chk("t2_lane16", out_flat[16*16 +: 16], 16'h8000);
    chk("t2_lane0", out_flat[15:0], 16'h0800);
    release_out("t2");

    // Saturation: lane larger than its group sum
    zero_sums();
    length_mode = 2'd0;
    data_flat = '0;
    data_flat[15:0] = 16'h0200;
    sum_64_0 = 16'h0100;
    run_check("t3_sat", 0, 0);
    chk("t3_sat_lane0", out_flat[15:0], 16'hFFFF);
    release_out("t3_sat");

    // Mode 1 with zero upper sum, then backpressure while valid_in is held
    zero_sums();
    length_mode = 2'd1;
    for (int i = 0; i < 64; i++) data_flat[i*16 +: 16] = (i < 32) ? 16'h0010 : 16'h0055;
    sum_32_0 = 16'h0200;
    run_check("t3_zero", 0, 0);
    chk("t3_zero_dz", div_zero, 4'b0010);
    valid_in  = 1'b1;
    data_flat = ~data_flat;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk_vec("t4_hold_out", out_flat, last_y);
      chk("t4_hold_valid", valid_out, 1);
      chk("t4_hold_ready", ready_in, 0);
    end
    release_out("t4");
    @(posedge clk); #1;
    chk("t4_no_accept", ready_in, 1);

    // Asynchronous reset in the middle of a division
    load_t1();
    do_accept();
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("t5_valid_out", valid_out, 0);
    chk_vec("t5_out_flat", out_flat, '0);
    chk("t5_div_zero", div_zero, 0);
    chk("t5_mode_out", length_mode_out, 0);
    chk("t5_ready_in", ready_in, 1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_check("t5_after", 0, 0);
    release_out("t5");

    // Clock enable low for 5 cycles mid-division
    load_t1();
    run_check("t6", 10, 5);
    release_out("t6");

    // Mode 3 behaves as mode 0
    load_t1();
    length_mode = 2'd3;
    run_check("t7_mode3", 0, 0);
    release_out("t7");

    // Random lanes with exact group sums, modes 2 and 1
    zero_sums();
    length_mode = 2'd2;
    for (int k = 0; k < 4; k++) acc[k] = 16'd0;
    for (int i = 0; i < 64; i++) begin
      v = 16'($urandom_range(1, 16'h0FFF));
      data_flat[i*16 +: 16] = v;
      acc[i/16] = acc[i/16] + v;
    end
    sum_16_0 = acc[0]; sum_16_1 = acc[1]; sum_16_2 = acc[2]; sum_16_3 = acc[3];
    run_check("t8_rand2", 0, 0);
    release_out("t8");

    zero_sums();
    length_mode = 2'd1;
    for (int k = 0; k < 4; k++) acc[k] = 16'd0;
    for (int i = 0; i < 64; i++) begin
      v = 16'($urandom_range(0, 16'h07FF));
      data_flat[i*16 +: 16] = v;
      acc[i/32] = acc[i/32] + v;
    end
    sum_32_0 = acc[0]; sum_32_1 = acc[1];
    run_check("t9_rand1", 0, 0);
    release_out("t9");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
